// File: rtl/ws2812_pkg.sv
// ws2812 shared types and default timing.
// State encodings plus 40 MHz bit/latch timing constants.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FWAIT,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } ws_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HIGH,
    PH_LOW
  } ws_phase_e;

  localparam int DEF_T0H_CYC   = 16;
  localparam int DEF_T1H_CYC   = 32;
  localparam int DEF_T0L_CYC   = 34;
  localparam int DEF_T1L_CYC   = 18;
  localparam int DEF_RESET_CYC = 2000;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812 single-bit waveform generator.
// A go pulse starts a HIGH/LOW pair; bit_done marks its last cycle.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int T0L_CYC = DEF_T0L_CYC,
  parameter int T1L_CYC = DEF_T1L_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_val,
  input  logic go,
  output logic dout,
  output logic bit_done
);

  localparam int MAXH = (T0H_CYC > T1H_CYC) ? T0H_CYC : T1H_CYC;
  localparam int MAXL = (T0L_CYC > T1L_CYC) ? T0L_CYC : T1L_CYC;
  localparam int MAXC = (MAXH > MAXL) ? MAXH : MAXL;
  localparam int PW   = $clog2(MAXC + 1);

  ws_phase_e       phase_q, phase_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            bit_q, bit_d;
  logic            dout_q, dout_d;

  // Phase sequencing; go wins so back-to-back bits have no gap.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    dout_d  = dout_q;
    if (go) begin
      phase_d = PH_HIGH;
      cnt_d   = bit_val ? PW'(T1H_CYC - 1) : PW'(T0H_CYC - 1);
      bit_d   = bit_val;
      dout_d  = 1'b1;
    end else begin
      unique case (phase_q)
        PH_IDLE: begin
          dout_d = 1'b0;
        end
        PH_HIGH: begin
          if (cnt_q == '0) begin
            phase_d = PH_LOW;
            cnt_d   = bit_q ? PW'(T1L_CYC - 1) : PW'(T0L_CYC - 1);
            dout_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
        PH_LOW: begin
          if (cnt_q == '0) phase_d = PH_IDLE;
          else cnt_d = cnt_q - PW'(1);
        end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  // Phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign bit_done = (phase_q == PH_LOW) && (cnt_q == '0);

endmodule

// File: rtl/ws2812_strip_driver.sv
// ws2812 frame streamer: pixel fetch, prefetch, shift and latch.
// Optional WS2812_BRIGHTNESS_EN adds a per-frame channel scaler.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int N_LEDS    = 64,
  parameter int BPP       = 24,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int T0L_CYC   = DEF_T0L_CYC,
  parameter int T1L_CYC   = DEF_T1L_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC,
  parameter int AW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pix_rd,
  output logic [AW-1:0]  pix_addr,
  input  logic [BPP-1:0] pix_data,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]     brightness,
`endif
  output logic           dout
);

  localparam int BW = $clog2(BPP);
  localparam int LW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  ws_state_e       state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]   pix_idx_q, pix_idx_d;
  logic [AW-1:0]   nxt_idx;
  logic [BPP-1:0]  shift_q, shift_d;
  logic [BPP-1:0]  pre_q, pre_d;
  logic            pf_cap_q, pf_cap_d;
  logic            pix_rd_q, pix_rd_d;
  logic [AW-1:0]   pix_addr_q, pix_addr_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic            started_q, started_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [BPP-1:0]  pix_in;
  logic            enc_go, enc_bit, enc_dout, enc_done;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]      bright_q, bright_d;

  function automatic logic [BPP-1:0] scale_word(
    input logic [BPP-1:0] w,
    input logic [7:0]     b
  );
    logic [BPP-1:0] r;
    logic [16:0]    prod;
    r = '0;
    for (int c = 0; c < BPP / 8; c++) begin
      prod = {9'd0, w[c*8 +: 8]} * ({9'd0, b} + 17'd1);
      r[c*8 +: 8] = prod[15:8];
    end
    return r;
  endfunction

  assign pix_in = scale_word(pix_data, bright_q);
`else
  assign pix_in = pix_data;
`endif

  assign nxt_idx = pix_idx_q + AW'(1);

  // Frame sequencing, prefetch and shift-register control.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pix_idx_d  = pix_idx_q;
    shift_d    = shift_q;
    pre_d      = pre_q;
    pix_addr_d = pix_addr_q;
    lat_cnt_d  = lat_cnt_q;
    started_d  = started_q;
`ifdef WS2812_BRIGHTNESS_EN
    bright_d   = bright_q;
`endif
    pix_rd_d   = 1'b0;
    done_d     = 1'b0;
    pf_cap_d   = pix_rd_q && (state_q == ST_HIGH);
    enc_go     = 1'b0;
    enc_bit    = 1'b0;
    if (pf_cap_q) pre_d = pix_in;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          pix_rd_d   = 1'b1;
          pix_addr_d = '0;
          pix_idx_d  = '0;
          started_d  = 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
          bright_d   = brightness;
`endif
        end
      end
      ST_FETCH: begin
        state_d = ST_FWAIT;
      end
      ST_FWAIT: begin
        shift_d   = pix_in;
        bit_cnt_d = BW'(BPP - 1);
        enc_go    = 1'b1;
        enc_bit   = pix_in[BPP-1];
        state_d   = ST_HIGH;
        if (N_LEDS > 1) begin
          pix_rd_d   = 1'b1;
          pix_addr_d = AW'(1);
        end
      end
      ST_HIGH: begin
        if (!enc_dout) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (enc_done) begin
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - BW'(1);
            enc_go    = 1'b1;
            enc_bit   = shift_q[BPP-2];
            state_d   = ST_HIGH;
          end else if (pix_idx_q != AW'(N_LEDS - 1)) begin
            shift_d   = pre_q;
            bit_cnt_d = BW'(BPP - 1);
            pix_idx_d = nxt_idx;
            enc_go    = 1'b1;
            enc_bit   = pre_q[BPP-1];
            state_d   = ST_HIGH;
            if (nxt_idx != AW'(N_LEDS - 1)) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = nxt_idx + AW'(1);
            end
          end else begin
            state_d   = ST_LATCH;
            lat_cnt_d = '0;
          end
        end
      end
      ST_LATCH: begin
        done_d = started_q && (lat_cnt_q == LW'(RESET_CYC - 2));
        if (lat_cnt_q == LW'(RESET_CYC - 1)) begin
          state_d   = ST_IDLE;
          started_d = 1'b0;
          lat_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset lands in a latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LATCH;
      bit_cnt_q  <= '0;
      pix_idx_q  <= '0;
      shift_q    <= '0;
      pre_q      <= '0;
      pf_cap_q   <= 1'b0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      lat_cnt_q  <= '0;
      started_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
      bright_q   <= 8'hFF;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pix_idx_q  <= pix_idx_d;
      shift_q    <= shift_d;
      pre_q      <= pre_d;
      pf_cap_q   <= pf_cap_d;
      pix_rd_q   <= pix_rd_d;
      pix_addr_q <= pix_addr_d;
      lat_cnt_q  <= lat_cnt_d;
      started_q  <= started_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef WS2812_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
    end
  end

  ws2812_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .T0L_CYC (T0L_CYC),
    .T1L_CYC (T1L_CYC)
  ) u_enc (
    .clk      (clk),
    .reset    (reset),
    .bit_val  (enc_bit),
    .go       (enc_go),
    .dout     (enc_dout),
    .bit_done (enc_done)
  );

  assign dout     = enc_dout;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pix_rd   = pix_rd_q;
  assign pix_addr = pix_addr_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Scoreboard bench for ws2812_strip_driver (3 pixels, 24 bpp).
// Builds with or without WS2812_BRIGHTNESS_EN.
module tb_ws2812_strip_driver;

  localparam int N   = 3;
  localparam int BPP = 24;
  localparam int RST = 2000;

  typedef struct {
    int hi;
    int lo;
    bit first;
    int t;
  } bit_t;

  typedef struct {
    int c;
    int a;
  } rd_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           busy, done, pix_rd, dout;
  logic [1:0]     pix_addr;
  logic [BPP-1:0] pix_data = '0;
  logic [7:0]     brightness = 8'hFF;

  logic [BPP-1:0] mem  [N];
  logic [BPP-1:0] expw [N];

  bit_t bq[$];
  rd_t  rq[$];
  int   dq[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int abort_cnt = 0;

  ws2812_strip_driver #(.N_LEDS(N), .BPP(BPP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .dout       (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [BPP-1:0] scale(input logic [BPP-1:0] w, input int b);
    logic [BPP-1:0] r;
    for (int c = 0; c < BPP / 8; c++)
      r[c*8 +: 8] = 8'((int'(w[c*8 +: 8]) * (b + 1)) / 256);
    return r;
  endfunction

  function automatic int hi_len(input logic b);
    return b ? 32 : 16;
  endfunction

  function automatic int lo_len(input logic b);
    return b ? 18 : 34;
  endfunction

  task automatic fill_exp();
    for (int i = 0; i < N; i++) begin
`ifdef WS2812_BRIGHTNESS_EN
      expw[i] = scale(mem[i], int'(brightness));
`else
      expw[i] = mem[i];
`endif
    end
  endtask

  // Push the whole frame's expected reads, pulses and done; returns done cycle.
  task automatic push_frame(input int s, output int d);
    int t;
    logic [BPP-1:0] w;
    bit_t e;
    rq.push_back('{c: s + 1, a: 0});
    t = s + 3;
    for (int i = 0; i < N; i++) begin
      w = expw[i];
      if (i < N - 1) rq.push_back('{c: t, a: i + 1});
      for (int b = BPP - 1; b >= 0; b--) begin
        e.hi = hi_len(w[b]);
        e.lo = lo_len(w[b]);
        e.first = (i == 0) && (b == BPP - 1);
        e.t = t;
        bq.push_back(e);
        t += e.hi + e.lo;
      end
    end
    d = t - 1 + RST;
    dq.push_back(d);
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_frame(output int d);
    fill_exp();
    push_frame(cyc, d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_latch(input string tag);
    int n = 0, dh = 0, dn = 0;
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (dout) dh++;
      if (done) dn++;
    end
    chk({tag, "_busy_len"}, n, RST);
    chk({tag, "_dout_high"}, dh, 0);
    chk({tag, "_done_cnt"}, dn, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_end(input int d, input string tag);
    wait_cyc(d + 3);
    chk({tag, "_done_left"}, dq.size(), 0);
    chk({tag, "_bits_left"}, bq.size(), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a pulse, read or done.
  initial begin
    int   seen = 0;
    int   hi_run = 0, lo_run = 0;
    int   exp_hi = 0, exp_lo = 0, nxt_lo = 0;
    logic prev = 1'b0;
    bit   in_pulse = 0;
    bit_t cur;
    rd_t  r;
    int   dexp;
    forever begin
      @(negedge clk);
      if (seen != abort_cnt) begin
        seen = abort_cnt;
        in_pulse = 0;
      end
      if (dout && !prev) begin
        if (bq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          cur = bq.pop_front();
          if (cur.first) chk("first_rise_cyc", cyc, cur.t);
          else chk("low_len", lo_run, exp_lo);
          exp_hi = cur.hi;
          nxt_lo = cur.lo;
          in_pulse = 1;
        end
        hi_run = 1;
      end else if (dout) begin
        hi_run++;
      end else if (prev && in_pulse) begin
        chk("high_len", hi_run, exp_hi);
        exp_lo = nxt_lo;
        lo_run = 1;
      end else begin
        lo_run++;
      end
      prev = dout;
      if (pix_rd) begin
        if (rq.size() == 0) begin
          chk("unexpected_rd", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("rd_cyc", cyc, r.c);
          chk("rd_addr", int'(pix_addr), r.a);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          dexp = dq.pop_front();
          chk("done_cyc", cyc, dexp);
        end
      end
    end
  end

  initial begin
    int d, d2, s2, tb;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 1);
    chk("rst_dout", int'(dout), 0);
    chk("rst_pix_rd", int'(pix_rd), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(pix_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_latch("por");

    // Directed pattern: two lone ones at bit 0 and bit 23 of the stream.
    mem[0] = 24'h800001;
    mem[1] = 24'h000000;
    mem[2] = 24'hFFFFFF;
    brightness = 8'hFF;
    issue_frame(d);
    frame_end(d, "directed");

`ifdef WS2812_BRIGHTNESS_EN
    mem[0] = 24'hFF8002;
    brightness = 8'd127;
    fill_exp();
    expw[0] = 24'h7F4001;
    push_frame(cyc, d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_end(d, "bright");
`endif

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) mem[i] = BPP'($urandom);
      brightness = 8'($urandom);
      issue_frame(d);
      frame_end(d, "random");
    end

    // Start held through a frame: accepted again only once IDLE is reached.
    for (int i = 0; i < N; i++) mem[i] = BPP'($urandom);
    fill_exp();
    push_frame(cyc, d);
    s2 = d + 1;
    push_frame(s2, d2);
    start = 1'b1;
    wait_cyc(s2 + 1);
    start = 1'b0;
    frame_end(d2, "held");

    // Start pulses mid-frame and on the done cycle are ignored.
    for (int i = 0; i < N; i++) mem[i] = BPP'($urandom);
    tb = cyc;
    issue_frame(d);
    wait_cyc(tb + 500);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc(d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_end(d, "ignored");

    // Reset during pixel 1, bit 10.
    for (int i = 0; i < N; i++) mem[i] = BPP'($urandom);
    tb = cyc;
    issue_frame(d);
    tb += 3;
    for (int b = BPP - 1; b >= 0; b--)
      tb += hi_len(expw[0][b]) + lo_len(expw[0][b]);
    for (int k = 0; k < 10; k++)
      tb += hi_len(expw[1][BPP-1-k]) + lo_len(expw[1][BPP-1-k]);
    wait_cyc(tb + 3);
    chk("abort_dout_pre", int'(dout), 1);
    bq.delete();
    rq.delete();
    dq.delete();
    abort_cnt++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_dout", int'(dout), 0);
    chk("abort_busy", int'(busy), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_latch("abort");
    repeat (5) @(posedge clk);
    #1;
    chk("final_rd_left", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
